hub75_row_capture: RTL and testbench

Receiving end of the HUB75 panel interface driven by our matrix clock/latch generator. Samples the HUB75 lines (CLK, LAT, OE, row address, upper/lower RGB) in the CLOCK_50 domain and reconstructs each shifted row. On every latch it presents the captured row bits, row address and bit count. It also measures the OE-active (low) pulse width. Used as an on-FPGA loopback checker for the driver and as the input stage of a panel-chaining bridge.

---
 rtl/hub75_row_capture.sv | 170 +++++++++++++++++
 tb/tb_hub75_row_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_row_capture.sv
// HUB75 receiver: synchronises the panel lines into CLOCK_50, rebuilds each shifted
// row, presents it on every latch, and measures how long OE stays low.
module hub75_row_capture #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8,
    parameter int OE_W  = 16
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             hub_clk,
    input  logic             hub_lat,
    input  logic             hub_oe,
    input  logic [3:0]       hub_addr,
    input  logic [2:0]       hub_rgb1,
    input  logic [2:0]       hub_rgb2,
    output logic             row_valid,
    output logic [3:0]       row_addr,
    output logic [WIDTH-1:0] row_r1,
    output logic [WIDTH-1:0] row_g1,
    output logic [WIDTH-1:0] row_b1,
    output logic [WIDTH-1:0] row_r2,
    output logic [WIDTH-1:0] row_g2,
    output logic [WIDTH-1:0] row_b2,
    output logic [CNT_W-1:0] row_count,
    output logic             row_overflow,
    output logic             oe_valid,
    output logic [OE_W-1:0]  oe_cycles
);

    // Sync chains: bit 0 = first stage, bit 1 = synced value, bit 2 = previous synced value.
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [2:0] lat_sync_q, lat_sync_d;
    logic [2:0] oe_sync_q,  oe_sync_d;
    logic [3:0] addr_s1_q, addr_s2_q;
    logic [5:0] rgb_s1_q,  rgb_s2_q;
    logic [1:0] arm_q, arm_d;

    // Plane order in the packed arrays: r1, g1, b1, r2, g2, b2.
    logic [5:0][WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [5:0][WIDTH-1:0] row_q, row_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_shift;
    logic                  ovf_q, ovf_d, ovf_shift;
    logic [3:0]            row_addr_q, row_addr_d;
    logic [CNT_W-1:0]      row_count_q, row_count_d;
    logic                  row_ovf_q, row_ovf_d;
    logic                  row_valid_q, row_valid_d;
    logic [OE_W-1:0]       oe_cnt_q, oe_cnt_d;
    logic [OE_W-1:0]       oe_cycles_q, oe_cycles_d;
    logic                  oe_valid_q, oe_valid_d;

    logic arm_done, clk_rise, lat_rise, oe_rise;

    // The s2/s3 pair is meaningless until the chain has refilled from live inputs,
    // so a line held high through reset must not look like a fresh edge.
    assign arm_done = (arm_q == 2'd3);
    assign clk_rise = arm_done & clk_sync_q[1] & ~clk_sync_q[2];
    assign lat_rise = arm_done & lat_sync_q[1] & ~lat_sync_q[2];
    assign oe_rise  = oe_sync_q[1] & ~oe_sync_q[2];

    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], hub_clk};
        lat_sync_d = {lat_sync_q[1:0], hub_lat};
        oe_sync_d  = {oe_sync_q[1:0],  hub_oe};
        arm_d      = arm_done ? arm_q : arm_q + 2'd1;

        sr_shift  = sr_q;
        cnt_shift = cnt_q;
        ovf_shift = ovf_q;
        if (clk_rise) begin
            for (int i = 0; i < 6; i++) begin
                sr_shift[i] = {sr_q[i][WIDTH-2:0], rgb_s2_q[i]};
            end
            if (cnt_q == CNT_W'(WIDTH)) begin
                ovf_shift = 1'b1;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_shift = cnt_q + CNT_W'(1);
            end
        end

        sr_d        = sr_shift;
        cnt_d       = cnt_shift;
        ovf_d       = ovf_shift;
        row_d       = row_q;
        row_addr_d  = row_addr_q;
        row_count_d = row_count_q;
        row_ovf_d   = row_ovf_q;
        row_valid_d = 1'b0;
        // A latch coinciding with a clock edge sees the post-shift state.
        if (lat_rise) begin
            row_d       = sr_shift;
            row_addr_d  = addr_s2_q;
            row_count_d = cnt_shift;
            row_ovf_d   = ovf_shift;
            row_valid_d = 1'b1;
            cnt_d       = '0;
            ovf_d       = 1'b0;
        end

        oe_cnt_d    = oe_cnt_q;
        oe_cycles_d = oe_cycles_q;
        oe_valid_d  = 1'b0;
        if (!oe_sync_q[1] && oe_cnt_q != {OE_W{1'b1}}) begin
            oe_cnt_d = oe_cnt_q + OE_W'(1);
        end
        if (oe_rise) begin
            oe_cycles_d = oe_cnt_q;
            oe_valid_d  = 1'b1;
            oe_cnt_d    = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 3'b000;
            lat_sync_q  <= 3'b000;
            oe_sync_q   <= 3'b111;
            addr_s1_q   <= '0;
            addr_s2_q   <= '0;
            rgb_s1_q    <= '0;
            rgb_s2_q    <= '0;
            arm_q       <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            row_q       <= '0;
            row_addr_q  <= '0;
            row_count_q <= '0;
            row_ovf_q   <= 1'b0;
            row_valid_q <= 1'b0;
            oe_cnt_q    <= '0;
            oe_cycles_q <= '0;
            oe_valid_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            lat_sync_q  <= lat_sync_d;
            oe_sync_q   <= oe_sync_d;
            addr_s1_q   <= hub_addr;
            addr_s2_q   <= addr_s1_q;
            rgb_s1_q    <= {hub_rgb2, hub_rgb1};
            rgb_s2_q    <= rgb_s1_q;
            arm_q       <= arm_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            row_q       <= row_d;
            row_addr_q  <= row_addr_d;
            row_count_q <= row_count_d;
            row_ovf_q   <= row_ovf_d;
            row_valid_q <= row_valid_d;
            oe_cnt_q    <= oe_cnt_d;
            oe_cycles_q <= oe_cycles_d;
            oe_valid_q  <= oe_valid_d;
        end
    end

    assign row_valid    = row_valid_q;
    assign row_addr     = row_addr_q;
    assign row_r1       = row_q[0];
    assign row_g1       = row_q[1];
    assign row_b1       = row_q[2];
    assign row_r2       = row_q[3];
    assign row_g2       = row_q[4];
    assign row_b2       = row_q[5];
    assign row_count    = row_count_q;
    assign row_overflow = row_ovf_q;
    assign oe_valid     = oe_valid_q;
    assign oe_cycles    = oe_cycles_q;

endmodule

// File: tb/tb_hub75_row_capture.sv
// Directed bench for hub75_row_capture: drives HUB75 waveforms and checks the
// captured rows and OE measurements against hand-computed values.
module tb_hub75_row_capture;

    localparam int WIDTH = 64;
    localparam int CNT_W = 8;
    localparam int OE_W  = 16;

    logic             CLOCK_50 = 1'b0;
    logic             rst_n    = 1'b0;
    logic             hub_clk  = 1'b0;
    logic             hub_lat  = 1'b0;
    logic             hub_oe   = 1'b1;
    logic [3:0]       hub_addr = '0;
    logic [2:0]       hub_rgb1 = '0;
    logic [2:0]       hub_rgb2 = '0;
    logic             row_valid;
    logic [3:0]       row_addr;
    logic [WIDTH-1:0] row_r1, row_g1, row_b1, row_r2, row_g2, row_b2;
    logic [CNT_W-1:0] row_count;
    logic             row_overflow;
    logic             oe_valid;
    logic [OE_W-1:0]  oe_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    hub75_row_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W), .OE_W(OE_W)) dut (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .hub_clk     (hub_clk),
        .hub_lat     (hub_lat),
        .hub_oe      (hub_oe),
        .hub_addr    (hub_addr),
        .hub_rgb1    (hub_rgb1),
        .hub_rgb2    (hub_rgb2),
        .row_valid   (row_valid),
        .row_addr    (row_addr),
        .row_r1      (row_r1),
        .row_g1      (row_g1),
        .row_b1      (row_b1),
        .row_r2      (row_r2),
        .row_g2      (row_g2),
        .row_b2      (row_b2),
        .row_count   (row_count),
        .row_overflow(row_overflow),
        .oe_valid    (oe_valid),
        .oe_cycles   (oe_cycles)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // One driver-style CLK period: data set up 1 cycle early, high 2, low 2.
    task automatic pulse(input logic [2:0] c1, input logic [2:0] c2);
        hub_rgb1 = c1;
        hub_rgb2 = c2;
        cyc(1);
        hub_clk = 1'b1;
        cyc(2);
        hub_clk = 1'b0;
        cyc(2);
    endtask

    // Raise LAT (optionally together with CLK) and count row_valid pulses in a bounded window.
    task automatic latch(input logic [3:0] a, input bit with_clk, output int npulse);
        hub_addr = a;
        cyc(1);
        hub_lat = 1'b1;
        if (with_clk) hub_clk = 1'b1;
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (row_valid === 1'b1) npulse++;
            if (i == 1) begin
                hub_lat = 1'b0;
                hub_clk = 1'b0;
            end
        end
        $display("row: addr=%0d count=%0d ovf=%0b r1=%h", row_addr, row_count, row_overflow, row_r1);
    endtask

    task automatic oe_low(input int n, output int npulse);
        hub_oe = 1'b0;
        cyc(n);
        hub_oe = 1'b1;
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (oe_valid === 1'b1) npulse++;
        end
        $display("oe: low=%0d measured=%0d pulses=%0d", n, oe_cycles, npulse);
    endtask

    task automatic test_reset;
        int nr, no;
        rst_n   = 1'b0;
        hub_oe  = 1'b0;
        hub_clk = 1'b1;
        cyc(3);
        n_checks += 6;
        if (row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_row_valid got %b want 0", row_valid); end
        if (oe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_oe_valid got %b want 0", oe_valid); end
        if (row_count !== '0) begin n_fail++; $display("FAIL reset_row_count got %0d want 0", row_count); end
        if (row_r1 !== '0 || row_b2 !== '0) begin n_fail++; $display("FAIL reset_rows got %h/%h want 0", row_r1, row_b2); end
        if (row_addr !== '0 || row_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ovf got %0d/%b want 0/0", row_addr, row_overflow); end
        if (oe_cycles !== '0) begin n_fail++; $display("FAIL reset_oe_cycles got %0d want 0", oe_cycles); end
        rst_n = 1'b1;
        nr = 0;
        no = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (row_valid === 1'b1) nr++;
            if (oe_valid === 1'b1) no++;
        end
        n_checks += 2;
        if (nr != 0) begin n_fail++; $display("FAIL release_row_valid got %0d pulses want 0", nr); end
        if (no != 0) begin n_fail++; $display("FAIL release_oe_valid got %0d pulses want 0", no); end
        hub_clk = 1'b0;
        hub_oe  = 1'b1;
        no = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (oe_valid === 1'b1) no++;
        end
        n_checks++;
        if (no != 1) begin n_fail++; $display("FAIL release_oe_rise got %0d pulses want 1", no); end
    endtask

    task automatic test_full_row;
        int np;
        for (int c = 0; c < WIDTH; c++) pulse((c % 2 == 0) ? 3'b001 : 3'b000, 3'b000);
        latch(4'd9, 1'b0, np);
        n_checks += 6;
        if (np != 1) begin n_fail++; $display("FAIL full_row_valid got %0d pulses want 1", np); end
        if (row_addr !== 4'd9) begin n_fail++; $display("FAIL full_row_addr got %0d want 9", row_addr); end
        if (row_r1 !== 64'hAAAA_AAAA_AAAA_AAAA) begin n_fail++; $display("FAIL full_row_r1 got %h want aaaaaaaaaaaaaaaa", row_r1); end
        if (row_g1 !== '0 || row_b1 !== '0 || row_r2 !== '0) begin n_fail++; $display("FAIL full_row_other got %h/%h/%h want 0", row_g1, row_b1, row_r2); end
        if (row_count !== 8'd64) begin n_fail++; $display("FAIL full_row_count got %0d want 64", row_count); end
        if (row_overflow !== 1'b0) begin n_fail++; $display("FAIL full_row_ovf got %b want 0", row_overflow); end
    endtask

    task automatic test_overflow;
        int np;
        for (int c = 0; c < 70; c++) pulse((c >= 6) ? 3'b001 : 3'b000, 3'b010);
        latch(4'd3, 1'b0, np);
        n_checks += 5;
        if (np != 1) begin n_fail++; $display("FAIL ovf_row_valid got %0d pulses want 1", np); end
        if (row_r1 !== {WIDTH{1'b1}}) begin n_fail++; $display("FAIL ovf_r1 got %h want all ones", row_r1); end
        if (row_g2 !== {WIDTH{1'b1}}) begin n_fail++; $display("FAIL ovf_g2 got %h want all ones", row_g2); end
        if (row_count !== 8'd70) begin n_fail++; $display("FAIL ovf_count got %0d want 70", row_count); end
        if (row_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", row_overflow); end
        for (int c = 0; c < 3; c++) pulse(3'b000, 3'b000);
        latch(4'd4, 1'b0, np);
        n_checks += 2;
        if (row_count !== 8'd3) begin n_fail++; $display("FAIL ovf_next_count got %0d want 3", row_count); end
        if (row_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag got %b want 0", row_overflow); end
    endtask

    task automatic test_coincident;
        int np;
        for (int c = 0; c < 5; c++) pulse(3'b000, 3'b000);
        hub_rgb1 = 3'b001;
        latch(4'd12, 1'b1, np);
        n_checks += 4;
        if (np != 1) begin n_fail++; $display("FAIL coinc_row_valid got %0d pulses want 1", np); end
        if (row_count !== 8'd6) begin n_fail++; $display("FAIL coinc_count got %0d want 6", row_count); end
        if (row_r1[5:0] !== 6'b000001) begin n_fail++; $display("FAIL coinc_r1 got %b want 000001", row_r1[5:0]); end
        if (row_addr !== 4'd12) begin n_fail++; $display("FAIL coinc_addr got %0d want 12", row_addr); end
        hub_rgb1 = 3'b000;
    endtask

    task automatic test_oe_width;
        int np;
        oe_low(80, np);
        n_checks += 2;
        if (np != 1) begin n_fail++; $display("FAIL oe80_pulses got %0d want 1", np); end
        if (oe_cycles !== 16'd80) begin n_fail++; $display("FAIL oe80_cycles got %0d want 80", oe_cycles); end
        oe_low(70000, np);
        n_checks += 2;
        if (np != 1) begin n_fail++; $display("FAIL oe_sat_pulses got %0d want 1", np); end
        if (oe_cycles !== 16'd65535) begin n_fail++; $display("FAIL oe_sat_cycles got %0d want 65535", oe_cycles); end
    endtask

    task automatic test_mid_row_reset;
        int np;
        for (int c = 0; c < 30; c++) pulse(3'b111, 3'b111);
        rst_n = 1'b0;
        cyc(1);
        n_checks++;
        if (row_count !== '0 || row_r1 !== '0 || oe_cycles !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear got count=%0d r1=%h oe=%0d want 0", row_count, row_r1, oe_cycles);
        end
        rst_n = 1'b1;
        cyc(4);
        pulse(3'b001, 3'b000);
        pulse(3'b000, 3'b000);
        pulse(3'b001, 3'b000);
        pulse(3'b001, 3'b000);
        latch(4'd5, 1'b0, np);
        n_checks += 4;
        if (np != 1) begin n_fail++; $display("FAIL midreset_row_valid got %0d pulses want 1", np); end
        if (row_count !== 8'd4) begin n_fail++; $display("FAIL midreset_count got %0d want 4", row_count); end
        if (row_r1 !== 64'hB) begin n_fail++; $display("FAIL midreset_r1 got %h want b", row_r1); end
        if (row_g1 !== '0 || row_b2 !== '0) begin n_fail++; $display("FAIL midreset_other got %h/%h want 0", row_g1, row_b2); end
    endtask

    initial begin
        test_reset();
        test_full_row();
        test_overflow();
        test_coincident();
        test_oe_width();
        test_mid_row_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
